// File: rtl/iq_gen_deadlock_report_decoder.sv
// Purpose : decodes the deadlock monitor's block flag and per-channel info word, declares a deadlock
//           after T consecutive blocked samples and offers one latched report.
// Latency : blocked_now 1 cycle; rpt_valid rises in the cycle after the edge capturing the T-th blocked sample.
// Backpr. : report is held (valid + stable payload) until rpt_ready; inputs are ignored while waiting.
//
// Ports:
//   clock, reset (async active-low)       - clocking
//   block, axis_block_info                - monitor inputs; channel k field at [k*FIELD_W +: FIELD_W]
//   threshold                             - consecutive blocked samples required (0 behaves as 1)
//   clear                                 - one-cycle rearm pulse, beats every other event
//   blocked_now                           - registered decoded blocked-channel mask
//   rpt_valid/rpt_ready, rpt_channel,
//   rpt_chan_mask, rpt_cycles             - report handshake and payload
//   deadlock, proto_err                   - sticky status flags
module iq_gen_deadlock_report_decoder #(
   parameter int NUM_CH   = 3,
   parameter int FIELD_W  = 3,
   parameter int THRESH_W = 16,
   parameter int CNT_W    = 32,
   parameter int CH_W     = 2
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        block,
   input  logic [NUM_CH*FIELD_W-1:0]   axis_block_info,
   input  logic [THRESH_W-1:0]         threshold,
   input  logic                        clear,
   output logic [NUM_CH-1:0]           blocked_now,
   output logic                        rpt_valid,
   input  logic                        rpt_ready,
   output logic [CH_W-1:0]             rpt_channel,
   output logic [NUM_CH-1:0]           rpt_chan_mask,
   output logic [CNT_W-1:0]            rpt_cycles,
   output logic                        deadlock,
   output logic                        proto_err
);

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_REPORT, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
   logic [CH_W-1:0]     first_ch_q, first_ch_d;
   logic [NUM_CH-1:0]   mask_acc_q, mask_acc_d;
   logic [CH_W-1:0]     rpt_channel_q, rpt_channel_d;
   logic [NUM_CH-1:0]   rpt_mask_q, rpt_mask_d;
   logic [CNT_W-1:0]    rpt_cycles_q, rpt_cycles_d;
   logic                deadlock_q, deadlock_d;
   logic                proto_err_q, proto_err_d;
   logic [NUM_CH-1:0]   blocked_now_q, blocked_now_d;

   // Field decode: channel k reports "blocked" with the one-cold pattern ~(1<<k);
   // anything other than that pattern or all-zero is malformed.
   logic [NUM_CH-1:0]   mask_c;
   logic                malformed_c;
   logic [FIELD_W-1:0]  fld_c, pat_c;
   logic [CH_W-1:0]     low_ch_c;

   always_comb begin
      mask_c      = '0;
      malformed_c = 1'b0;
      fld_c       = '0;
      pat_c       = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         fld_c = axis_block_info[k*FIELD_W +: FIELD_W];
         pat_c = ~(FIELD_W'(1) << k);
         if (fld_c == pat_c)
            mask_c[k] = 1'b1;
         else if (fld_c != '0)
            malformed_c = 1'b1;
      end
      low_ch_c = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (mask_c[k]) low_ch_c = CH_W'(k);
      end
   end

   logic               valid_c, proto_c;
   logic [CNT_W-1:0]   t_eff_c, cnt_inc_c;

   assign valid_c   = block && (mask_c != '0);
   assign proto_c   = malformed_c || (block && (mask_c == '0)) || (!block && (axis_block_info != '0));
   assign t_eff_c   = (threshold == '0) ? CNT_W'(1) : CNT_W'(threshold);
   assign cnt_inc_c = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + CNT_W'(1);

   always_comb begin
      state_d       = state_q;
      run_cnt_d     = run_cnt_q;
      first_ch_d    = first_ch_q;
      mask_acc_d    = mask_acc_q;
      rpt_channel_d = rpt_channel_q;
      rpt_mask_d    = rpt_mask_q;
      rpt_cycles_d  = rpt_cycles_q;
      deadlock_d    = deadlock_q;
      proto_err_d   = proto_err_q | proto_c;
      // An inconsistent sample never contributes blocked channels.
      blocked_now_d = block ? mask_c : '0;

      unique case (state_q)
         S_IDLE: begin
            if (valid_c) begin
               run_cnt_d  = CNT_W'(1);
               first_ch_d = low_ch_c;
               mask_acc_d = mask_c;
               if (t_eff_c == CNT_W'(1)) begin
                  state_d       = S_REPORT;
                  rpt_channel_d = low_ch_c;
                  rpt_mask_d    = mask_c;
                  rpt_cycles_d  = CNT_W'(1);
                  deadlock_d    = 1'b1;
               end else begin
                  state_d = S_COUNT;
               end
            end
         end
         S_COUNT: begin
            if (valid_c) begin
               run_cnt_d  = cnt_inc_c;
               mask_acc_d = mask_acc_q | mask_c;
               // >= so a threshold lowered below the running count fires on the next sample.
               if (cnt_inc_c >= t_eff_c) begin
                  state_d       = S_REPORT;
                  rpt_channel_d = first_ch_q;
                  rpt_mask_d    = mask_acc_q | mask_c;
                  rpt_cycles_d  = cnt_inc_c;
                  deadlock_d    = 1'b1;
               end
            end else begin
               state_d    = S_IDLE;
               run_cnt_d  = '0;
               mask_acc_d = '0;
            end
         end
         S_REPORT: begin
            if (rpt_ready) state_d = S_DONE;
         end
         default: ;  // S_DONE: hold until clear
      endcase

      if (clear) begin
         state_d       = S_IDLE;
         run_cnt_d     = '0;
         first_ch_d    = '0;
         mask_acc_d    = '0;
         rpt_channel_d = '0;
         rpt_mask_d    = '0;
         rpt_cycles_d  = '0;
         deadlock_d    = 1'b0;
         proto_err_d   = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         run_cnt_q     <= '0;
         first_ch_q    <= '0;
         mask_acc_q    <= '0;
         rpt_channel_q <= '0;
         rpt_mask_q    <= '0;
         rpt_cycles_q  <= '0;
         deadlock_q    <= 1'b0;
         proto_err_q   <= 1'b0;
         blocked_now_q <= '0;
      end else begin
         state_q       <= state_d;
         run_cnt_q     <= run_cnt_d;
         first_ch_q    <= first_ch_d;
         mask_acc_q    <= mask_acc_d;
         rpt_channel_q <= rpt_channel_d;
         rpt_mask_q    <= rpt_mask_d;
         rpt_cycles_q  <= rpt_cycles_d;
         deadlock_q    <= deadlock_d;
         proto_err_q   <= proto_err_d;
         blocked_now_q <= blocked_now_d;
      end
   end

   assign rpt_valid     = (state_q == S_REPORT);
   assign rpt_channel   = rpt_channel_q;
   assign rpt_chan_mask = rpt_mask_q;
   assign rpt_cycles    = rpt_cycles_q;
   assign deadlock      = deadlock_q;
   assign proto_err     = proto_err_q;
   assign blocked_now   = blocked_now_q;

endmodule

// File: tb/tb_iq_gen_deadlock_report_decoder.sv
// Directed bench for iq_gen_deadlock_report_decoder: drives hand-built monitor samples and
// compares every output against hand-computed values with immediate assertions.
module tb_iq_gen_deadlock_report_decoder;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        block = 1'b0;
   logic [8:0]  axis_block_info = '0;
   logic [15:0] threshold = 16'd4;
   logic        clear = 1'b0;
   logic [2:0]  blocked_now;
   logic        rpt_valid;
   logic        rpt_ready = 1'b0;
   logic [1:0]  rpt_channel;
   logic [2:0]  rpt_chan_mask;
   logic [31:0] rpt_cycles;
   logic        deadlock;
   logic        proto_err;

   int checks = 0;
   int errors = 0;

   localparam logic [8:0] CH0 = 9'b000_000_110;
   localparam logic [8:0] CH1 = 9'b000_101_000;
   localparam logic [8:0] CH2 = 9'b011_000_000;

   iq_gen_deadlock_report_decoder dut (
      .clock           (clock),
      .reset           (reset),
      .block           (block),
      .axis_block_info (axis_block_info),
      .threshold       (threshold),
      .clear           (clear),
      .blocked_now     (blocked_now),
      .rpt_valid       (rpt_valid),
      .rpt_ready       (rpt_ready),
      .rpt_channel     (rpt_channel),
      .rpt_chan_mask   (rpt_chan_mask),
      .rpt_cycles      (rpt_cycles),
      .deadlock        (deadlock),
      .proto_err       (proto_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic pulse_clear();
      block = 1'b0; axis_block_info = '0; rpt_ready = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_valid", 32'(rpt_valid), 32'd0);
      chk("rst_deadlock", 32'(deadlock), 32'd0);
      chk("rst_proto", 32'(proto_err), 32'd0);
      chk("rst_blocked", 32'(blocked_now), 32'd0);
      chk("rst_cycles", rpt_cycles, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      tick();

      // 1: short run of 3 below threshold 4
      threshold = 16'd4;
      block = 1'b1; axis_block_info = CH1;
      #1;
      chk("t1_blk_delay", 32'(blocked_now), 32'd0);
      tick();
      chk("t1_blk_now", 32'(blocked_now), 32'b010);
      tick(2);
      chk("t1_no_valid3", 32'(rpt_valid), 32'd0);
      block = 1'b0; axis_block_info = '0;
      tick();
      chk("t1_blk_clr", 32'(blocked_now), 32'd0);
      tick(3);
      chk("t1_no_valid", 32'(rpt_valid), 32'd0);
      chk("t1_no_dead", 32'(deadlock), 32'd0);
      chk("t1_no_proto", 32'(proto_err), 32'd0);

      // 2: ch2 held, report held under backpressure
      block = 1'b1; axis_block_info = CH2;
      tick(3);
      chk("t2_valid_e3", 32'(rpt_valid), 32'd0);
      tick();
      chk("t2_valid_e4", 32'(rpt_valid), 32'd1);
      chk("t2_dead", 32'(deadlock), 32'd1);
      chk("t2_chan", 32'(rpt_channel), 32'd2);
      chk("t2_mask", 32'(rpt_chan_mask), 32'b100);
      chk("t2_cycles", rpt_cycles, 32'd4);
      tick(4);
      block = 1'b0; axis_block_info = '0;
      tick();
      chk("t2_hold_valid", 32'(rpt_valid), 32'd1);
      chk("t2_hold_chan", 32'(rpt_channel), 32'd2);
      chk("t2_hold_mask", 32'(rpt_chan_mask), 32'b100);
      chk("t2_hold_cycles", rpt_cycles, 32'd4);
      rpt_ready = 1'b1;
      tick();
      rpt_ready = 1'b0;
      chk("t2_valid_drop", 32'(rpt_valid), 32'd0);
      chk("t2_dead_sticky", 32'(deadlock), 32'd1);
      chk("t2_keep_cycles", rpt_cycles, 32'd4);
      // No second report while DONE, even with T=1
      threshold = 16'd1;
      block = 1'b1; axis_block_info = CH0;
      tick(2);
      chk("t2_done_noreport", 32'(rpt_valid), 32'd0);
      chk("t2_done_chan", 32'(rpt_channel), 32'd2);
      pulse_clear();
      chk("t2_clr_dead", 32'(deadlock), 32'd0);
      chk("t2_clr_cycles", rpt_cycles, 32'd0);
      chk("t2_clr_mask", 32'(rpt_chan_mask), 32'd0);

      // 3: ch0 then ch0+ch2, T=3
      threshold = 16'd3;
      block = 1'b1; axis_block_info = CH0;
      tick();
      axis_block_info = 9'b011_000_110;
      tick();
      chk("t3_valid_e2", 32'(rpt_valid), 32'd0);
      chk("t3_blk_now", 32'(blocked_now), 32'b101);
      tick();
      chk("t3_valid", 32'(rpt_valid), 32'd1);
      chk("t3_chan", 32'(rpt_channel), 32'd0);
      chk("t3_mask", 32'(rpt_chan_mask), 32'b101);
      chk("t3_cycles", rpt_cycles, 32'd3);
      block = 1'b0; axis_block_info = '0; rpt_ready = 1'b1;
      tick();
      chk("t3_accept", 32'(rpt_valid), 32'd0);
      pulse_clear();

      // 4: malformed and inconsistent samples
      threshold = 16'd1;
      block = 1'b1; axis_block_info = 9'b000_000_111;
      tick();
      chk("t4_proto_bad", 32'(proto_err), 32'd1);
      chk("t4_no_rpt", 32'(rpt_valid), 32'd0);
      chk("t4_blk_now", 32'(blocked_now), 32'd0);
      pulse_clear();
      chk("t4_proto_clr", 32'(proto_err), 32'd0);
      block = 1'b0; axis_block_info = CH1;
      tick();
      chk("t4_proto_noblk", 32'(proto_err), 32'd1);
      chk("t4_no_rpt2", 32'(rpt_valid), 32'd0);
      pulse_clear();
      block = 1'b1; axis_block_info = '0;
      tick();
      chk("t4_proto_empty", 32'(proto_err), 32'd1);
      pulse_clear();

      // 5: threshold 0 acts as 1; clear beats handshake
      threshold = 16'd0;
      block = 1'b1; axis_block_info = CH1;
      tick();
      chk("t5_valid", 32'(rpt_valid), 32'd1);
      chk("t5_cycles", rpt_cycles, 32'd1);
      chk("t5_chan", 32'(rpt_channel), 32'd1);
      block = 1'b0; axis_block_info = '0;
      rpt_ready = 1'b1; clear = 1'b1;
      tick();
      clear = 1'b0; rpt_ready = 1'b0;
      chk("t5_clr_valid", 32'(rpt_valid), 32'd0);
      chk("t5_clr_dead", 32'(deadlock), 32'd0);
      chk("t5_clr_cycles", rpt_cycles, 32'd0);
      // Back in IDLE (not DONE): a new sample reports again
      block = 1'b1; axis_block_info = CH1;
      tick();
      chk("t5_rearmed", 32'(rpt_valid), 32'd1);
      pulse_clear();

      // 6: asynchronous reset mid-report
      threshold = 16'd2;
      block = 1'b1; axis_block_info = 9'b000_000_111;
      tick();
      axis_block_info = CH2;
      tick(2);
      chk("t6_valid", 32'(rpt_valid), 32'd1);
      chk("t6_proto", 32'(proto_err), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_async_valid", 32'(rpt_valid), 32'd0);
      chk("t6_async_dead", 32'(deadlock), 32'd0);
      chk("t6_async_proto", 32'(proto_err), 32'd0);
      chk("t6_async_blk", 32'(blocked_now), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      tick();
      chk("t6_rerun_e1", 32'(rpt_valid), 32'd0);
      tick();
      chk("t6_rerun_valid", 32'(rpt_valid), 32'd1);
      chk("t6_rerun_cycles", rpt_cycles, 32'd2);
      chk("t6_rerun_chan", 32'(rpt_channel), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iq_gen_deadlock_report_decoder.md
Name: iq_gen_deadlock_report_decoder

Overview:
Consumer end of the per-instance deadlock monitor interface. Takes the monitor's `block` flag and the packed `axis_block_info` word and decodes which AXIS channels are stalled. It requires a configurable number of consecutive blocked cycles before declaring a deadlock, then presents one latched report on a valid/ready port for the debug/status register block. Sits beside iq_gen, one instance per monitored instance.

Parameters:
NUM_CH, 3, number of AXIS channels in the info word
FIELD_W, 3, bits per channel field; info width = NUM_CH*FIELD_W
THRESH_W, 16, width of threshold input
CNT_W, 32, width of blocked-cycle counter
CH_W, 2, width of channel index (>= clog2(NUM_CH))

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
block  in  1  monitor block flag
axis_block_info  in  NUM_CH*FIELD_W  packed per-channel fields; ch k at [k*FIELD_W +: FIELD_W]
threshold  in  THRESH_W  consecutive blocked samples required; 0 treated as 1
clear  in  1  one-cycle pulse; rearms detector
blocked_now  out  NUM_CH  registered decoded mask
rpt_valid  out  1  report valid
rpt_ready  in  1  report accept
rpt_channel  out  CH_W  lowest-index channel blocked in first blocked sample
rpt_chan_mask  out  NUM_CH  OR of all channels blocked during the run
rpt_cycles  out  CNT_W  consecutive blocked samples at declaration
deadlock  out  1  sticky deadlock flag
proto_err  out  1  sticky malformed-input flag

Behaviour:
- Reset (reset=0, async): all outputs 0, counters 0, FSM=IDLE. Takes effect immediately, including mid-report.
- Field decode per channel k:
  - field == ~(1<<k) truncated to FIELD_W → channel blocked (ch0=110, ch1=101, ch2=011).
  - field == 0 → not blocked.
  - Any other value → malformed: set proto_err and treat the channel as not blocked.
- Valid sample: block=1 and decoded mask != 0.
- Inconsistent sample: block=1 with mask==0, or block=0 with any nonzero field. Sets proto_err and counts as not blocked.
- blocked_now: decoded mask registered every cycle, 1-cycle latency, independent of FSM state.
- Effective threshold: T = max(threshold, 1), sampled every cycle.
- FSM states: IDLE, COUNT, REPORT, DONE.
  - IDLE:
    - On a valid sample → run_cnt=1, first_ch=lowest set bit, mask_acc=mask.
    - If T==1 → REPORT; else → COUNT.
  - COUNT:
    - On a valid sample → run_cnt+1 (saturating at all-ones), mask_acc |= mask.
    - When the updated run_cnt == T → REPORT. Same edge: latch rpt_* from the updated values, set rpt_valid=1 and deadlock=1.
    - On a non-valid sample → IDLE; run discarded, run_cnt=0.
  - REPORT:
    - rpt_valid held at 1; payload stable until accepted.
    - rpt_valid & rpt_ready at an edge → rpt_valid=0, → DONE.
    - Input activity is ignored.
  - DONE:
    - deadlock stays 1; payload retained; no new report is generated.
- clear, any state → IDLE next edge. It zeroes rpt_valid, deadlock, proto_err, run_cnt, mask_acc and payload.
  - clear has priority over every simultaneous event, including a handshake or a threshold hit on the same edge.
  - A valid sample on the clear edge is discarded; counting restarts from the next sample.
- Latency: rpt_valid is visible in the cycle after the edge that captured the T-th consecutive valid sample.
- Threshold change mid-COUNT: compare against the new T. If run_cnt already > T, declare on the next valid sample.

Test Plan:
1. T=4, info=9'b000_101_000 with block=1 for 3 cycles, then 0 → no rpt_valid; deadlock=0; blocked_now=3'b010 during the run, 1 cycle delayed.
2. T=4, ch2 field 011 with block held 8 cycles, rpt_ready=0 for 5 cycles after rpt_valid, then 1 → rpt_valid rises after the 4th edge. Payload rpt_channel=2, rpt_chan_mask=3'b100, rpt_cycles=4, stable while waiting. rpt_valid falls 1 cycle after ready. deadlock stays 1 until a clear pulse, then 0.
3. T=3, ch0 alone for 1 cycle, then ch0+ch2 (info=9'b011_000_110) → rpt_channel=0, rpt_chan_mask=3'b101, rpt_cycles=3.
4. block=1, ch0 field 111, others 0 → proto_err=1 next cycle; FSM stays IDLE; no report. block=0 with ch1=101 → proto_err=1.
5. threshold=0, single valid ch1 sample → REPORT after 1 edge, rpt_cycles=1. Clear on the same edge as rpt_ready → rpt_valid=0, deadlock=0, IDLE.
6. In REPORT, drive reset low asynchronously between edges → rpt_valid, deadlock and proto_err drop immediately without a clock. After release, a fresh T-sample run produces a new report.
